// File: rtl/score_combo_manager.sv
// Rhythm-game scoring: accumulates score, combo and judgment counts over one song
// through an IDLE/PLAY/DONE sequence.
module score_combo_manager #(
    parameter int unsigned TOTAL_NOTES = 32,
    parameter int unsigned MAX_SCORE   = 1000000,
    parameter int unsigned SCORE_W     = 20,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic               judge_valid,
    input  logic [1:0]         judge_grade,
    output logic [SCORE_W-1:0] score,
    output logic [COUNT_W-1:0] combo,
    output logic [COUNT_W-1:0] max_combo,
    output logic [COUNT_W-1:0] notes_judged,
    output logic [COUNT_W-1:0] perfect_cnt,
    output logic [COUNT_W-1:0] miss_cnt,
    output logic               playing,
    output logic               done,
    output logic               full_combo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned STEP = MAX_SCORE / TOTAL_NOTES;
    localparam logic [SCORE_W:0]   INC_PERFECT = (SCORE_W+1)'(STEP);
    localparam logic [SCORE_W:0]   INC_GREAT   = (SCORE_W+1)'((STEP * 3) / 4);
    localparam logic [SCORE_W:0]   INC_GOOD    = (SCORE_W+1)'(STEP / 2);
    localparam logic [SCORE_W:0]   MAX_EXT     = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_OUT     = SCORE_W'(MAX_SCORE);
    localparam logic [COUNT_W-1:0] TOTAL_C     = COUNT_W'(TOTAL_NOTES);

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COUNT_W-1:0] combo_q, combo_d;
    logic [COUNT_W-1:0] maxc_q, maxc_d;
    logic [COUNT_W-1:0] notes_q, notes_d;
    logic [COUNT_W-1:0] perf_q, perf_d;
    logic [COUNT_W-1:0] miss_q, miss_d;
    logic               playing_q, playing_d;
    logic               done_q, done_d;
    logic               fc_q, fc_d;
    logic [SCORE_W:0]   inc;
    logic [SCORE_W:0]   sum;

    always_comb begin
        case (judge_grade)
            2'd3:    inc = INC_PERFECT;
            2'd2:    inc = INC_GREAT;
            2'd1:    inc = INC_GOOD;
            default: inc = '0;
        endcase
        sum = {1'b0, score_q} + inc;
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        combo_d   = combo_q;
        maxc_d    = maxc_q;
        notes_d   = notes_q;
        perf_d    = perf_q;
        miss_d    = miss_q;
        playing_d = playing_q;
        done_d    = done_q;
        fc_d      = fc_q;
        if (clear) begin
            state_d   = S_IDLE;
            score_d   = '0;
            combo_d   = '0;
            maxc_d    = '0;
            notes_d   = '0;
            perf_d    = '0;
            miss_d    = '0;
            playing_d = 1'b0;
            done_d    = 1'b0;
            fc_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // a judgment arriving with start is intentionally dropped
                    if (start) begin
                        state_d   = S_PLAY;
                        score_d   = '0;
                        combo_d   = '0;
                        maxc_d    = '0;
                        notes_d   = '0;
                        perf_d    = '0;
                        miss_d    = '0;
                        playing_d = 1'b1;
                        done_d    = 1'b0;
                        fc_d      = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (judge_valid) begin
                        notes_d = notes_q + 1'b1;
                        if (judge_grade == 2'd3) perf_d = perf_q + 1'b1;
                        if (judge_grade == 2'd0) begin
                            miss_d  = miss_q + 1'b1;
                            combo_d = '0;
                        end else if (combo_q != '1) begin
                            combo_d = combo_q + 1'b1;
                        end
                        maxc_d  = (combo_d > maxc_q) ? combo_d : maxc_q;
                        score_d = (sum > MAX_EXT) ? MAX_OUT : sum[SCORE_W-1:0];
                        if (notes_d == TOTAL_C) begin
                            state_d   = S_DONE;
                            playing_d = 1'b0;
                            done_d    = 1'b1;
                            fc_d      = (miss_d == '0);
                            // all-PERFECT absorbs the integer-division remainder
                            if (perf_d == TOTAL_C) score_d = MAX_OUT;
                        end
                    end
                end
                S_DONE: ;
                default: begin
                    state_d   = S_IDLE;
                    playing_d = 1'b0;
                    done_d    = 1'b0;
                    fc_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            combo_q   <= '0;
            maxc_q    <= '0;
            notes_q   <= '0;
            perf_q    <= '0;
            miss_q    <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            fc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            maxc_q    <= maxc_d;
            notes_q   <= notes_d;
            perf_q    <= perf_d;
            miss_q    <= miss_d;
            playing_q <= playing_d;
            done_q    <= done_d;
            fc_q      <= fc_d;
        end
    end

    assign score        = score_q;
    assign combo        = combo_q;
    assign max_combo    = maxc_q;
    assign notes_judged = notes_q;
    assign perfect_cnt  = perf_q;
    assign miss_cnt     = miss_q;
    assign playing      = playing_q;
    assign done         = done_q;
    assign full_combo   = fc_q;

endmodule

// File: tb/tb_score_combo_manager.sv
// Scoreboard bench: two instances (32-note default and 3-note) driven in lockstep,
// checked against a history-based song model.
module tb_score_combo_manager;

    localparam int MAXS = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic judge_valid = 1'b0;
    logic [1:0] judge_grade = 2'd0;

    logic [19:0] score_a, score_b;
    logic [7:0]  combo_a, maxc_a, notes_a, perf_a, miss_a;
    logic [7:0]  combo_b, maxc_b, notes_b, perf_b, miss_b;
    logic        pl_a, dn_a, fc_a, pl_b, dn_b, fc_b;

    score_combo_manager u_dut32 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .judge_valid(judge_valid), .judge_grade(judge_grade),
        .score(score_a), .combo(combo_a), .max_combo(maxc_a),
        .notes_judged(notes_a), .perfect_cnt(perf_a), .miss_cnt(miss_a),
        .playing(pl_a), .done(dn_a), .full_combo(fc_a)
    );

    score_combo_manager #(.TOTAL_NOTES(3), .MAX_SCORE(1000000), .SCORE_W(20), .COUNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .judge_valid(judge_valid), .judge_grade(judge_grade),
        .score(score_b), .combo(combo_b), .max_combo(maxc_b),
        .notes_judged(notes_b), .perfect_cnt(perf_b), .miss_cnt(miss_b),
        .playing(pl_b), .done(dn_b), .full_combo(fc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score; int combo; int maxc; int notes; int perf; int miss;
        int pl; int dn; int fc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int vectors = 0;
    int miscompares = 0;

    // song model: 0 idle, 1 playing, 2 finished; grades holds this song's history
    int mode[2];
    int ncnt[2];
    int grades[2][64];
    int totals[2] = '{32, 3};

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        int step, sum, run, tot;
        e = '{default: 0};
        tot = totals[k];
        step = MAXS / tot;
        sum = 0;
        run = 0;
        if (mode[k] == 0) return e;
        for (int i = 0; i < ncnt[k]; i++) begin
            case (grades[k][i])
                3: begin sum += step; e.perf++; end
                2: sum += (step * 3) / 4;
                1: sum += step / 2;
                default: e.miss++;
            endcase
            if (grades[k][i] == 0) run = 0;
            else if (run < 255) run++;
            if (run > e.maxc) e.maxc = run;
        end
        e.combo = run;
        e.notes = ncnt[k];
        e.score = (sum > MAXS) ? MAXS : sum;
        if (ncnt[k] == tot && e.perf == tot) e.score = MAXS;
        e.pl = (mode[k] == 1) ? 1 : 0;
        e.dn = (mode[k] == 2) ? 1 : 0;
        e.fc = (mode[k] == 2 && e.miss == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic model_step(input bit st, input bit cl, input bit jv, input int g);
        for (int k = 0; k < 2; k++) begin
            if (cl) begin
                mode[k] = 0; ncnt[k] = 0;
            end else if (mode[k] == 0) begin
                if (st) begin mode[k] = 1; ncnt[k] = 0; end
            end else if (mode[k] == 1 && jv) begin
                grades[k][ncnt[k]] = g;
                ncnt[k]++;
                if (ncnt[k] == totals[k]) mode[k] = 2;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit cl, input bit jv, input int g);
        @(negedge clk);
        rst = 1'b0;
        start = st;
        clear = cl;
        judge_valid = jv;
        judge_grade = 2'(g);
        model_step(st, cl, jv, g);
        qa.push_back(expect_of(0));
        qb.push_back(expect_of(1));
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, ".score"}, int'(score_a), 0);
        cmp({tag, ".combo"}, int'(combo_a), 0);
        cmp({tag, ".max_combo"}, int'(maxc_a), 0);
        cmp({tag, ".notes"}, int'(notes_a), 0);
        cmp({tag, ".perfect"}, int'(perf_a), 0);
        cmp({tag, ".miss"}, int'(miss_a), 0);
        cmp({tag, ".flags"}, int'({pl_a, dn_a, fc_a}), 0);
        cmp({tag, ".b_score"}, int'(score_b), 0);
        cmp({tag, ".b_flags"}, int'({pl_b, dn_b, fc_b}), 0);
    endtask

    // asserted between edges so the async clear is observed before any clock
    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        judge_valid = 1'b1;
        judge_grade = 2'd3;
        for (int k = 0; k < 2; k++) begin mode[k] = 0; ncnt[k] = 0; end
        #1;
        check_zero("async_rst");
        qa.push_back(expect_of(0));
        qb.push_back(expect_of(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_one(input string tag, input exp_t e, input int s, input int c,
                             input int m, input int n, input int p, input int mi,
                             input logic pl, input logic dn, input logic fc);
        cmp({tag, ".score"}, s, e.score);
        cmp({tag, ".combo"}, c, e.combo);
        cmp({tag, ".max_combo"}, m, e.maxc);
        cmp({tag, ".notes"}, n, e.notes);
        cmp({tag, ".perfect"}, p, e.perf);
        cmp({tag, ".miss"}, mi, e.miss);
        cmp({tag, ".playing"}, int'(pl), e.pl);
        cmp({tag, ".done"}, int'(dn), e.dn);
        cmp({tag, ".full_combo"}, int'(fc), e.fc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check_one("dut32", e, int'(score_a), int'(combo_a), int'(maxc_a), int'(notes_a),
                          int'(perf_a), int'(miss_a), pl_a, dn_a, fc_a);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check_one("dut3", e, int'(score_b), int'(combo_b), int'(maxc_b), int'(notes_b),
                          int'(perf_b), int'(miss_b), pl_b, dn_b, fc_b);
            end
        end
    end

    initial begin : driver
        bit st, cl, jv;
        int g;
        for (int k = 0; k < 2; k++) begin mode[k] = 0; ncnt[k] = 0; end

        apply_rst();

        cycle(1, 0, 1, 3);
        cycle(0, 0, 1, 3);
        settle();
        cmp("start_with_judge.score", int'(score_a), 31250);
        cmp("start_with_judge.notes", int'(notes_a), 1);

        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (32) cycle(0, 0, 1, 3);
        settle();
        cmp("all_perfect.score", int'(score_a), 1000000);
        cmp("all_perfect.combo", int'(combo_a), 32);
        cmp("all_perfect.max_combo", int'(maxc_a), 32);
        cmp("all_perfect.done", int'(dn_a), 1);
        cmp("all_perfect.full_combo", int'(fc_a), 1);
        cmp("three_note.score", int'(score_b), 1000000);
        cmp("three_note.done", int'(dn_b), 1);

        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (10) cycle(0, 0, 1, 3);
        cycle(0, 0, 1, 0);
        repeat (5) cycle(0, 0, 1, 2);
        settle();
        cmp("mixed.score", int'(score_a), 429685);
        cmp("mixed.combo", int'(combo_a), 5);
        cmp("mixed.max_combo", int'(maxc_a), 10);
        cmp("mixed.miss", int'(miss_a), 1);
        cmp("mixed.playing", int'(pl_a), 1);

        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (32) cycle(0, 0, 1, 1);
        settle();
        cmp("all_good.score", int'(score_a), 500000);
        cmp("all_good.done", int'(dn_a), 1);
        cmp("all_good.full_combo", int'(fc_a), 1);
        cycle(1, 0, 1, 3);
        settle();
        cmp("after_done.score", int'(score_a), 500000);
        cmp("after_done.notes", int'(notes_a), 32);
        cmp("after_done.done", int'(dn_a), 1);

        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (7) cycle(0, 0, 1, 3);
        apply_rst();
        cycle(0, 0, 1, 3);
        settle();
        cmp("post_rst.notes", int'(notes_a), 0);
        cmp("post_rst.score", int'(score_a), 0);
        cmp("post_rst.playing", int'(pl_a), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_rst();
            end else begin
                st = ($urandom_range(0, 9) == 0);
                cl = ($urandom_range(0, 59) == 0);
                jv = ($urandom_range(0, 4) != 0);
                g  = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 3));
                cycle(st, cl, jv, g);
            end
        end

        repeat (3) cycle(0, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_combo_manager.md
SCORE_COMBO_MANAGER -- requirements
Module: score_combo_manager

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter TOTAL_NOTES, default 32: number of judgments in one song.
REQ-003 Parameter MAX_SCORE, default 1000000: score for an all-PERFECT run.
REQ-004 Parameter SCORE_W, default 20: width of score; MAX_SCORE SHALL fit in SCORE_W bits.
REQ-005 Parameter COUNT_W, default 8: width of all combo and note counters; TOTAL_NOTES SHALL fit in COUNT_W bits.
REQ-006 Port clk, input, 1: system clock.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port start, input, 1: one-cycle pulse that begins a song.
REQ-009 Port clear, input, 1: synchronous return to IDLE with all outputs zeroed.
REQ-010 Port judge_valid, input, 1: one-cycle pulse per judged note.
REQ-011 Port judge_grade, input, 2: judged grade, 0 MISS, 1 GOOD, 2 GREAT, 3 PERFECT; sampled only when judge_valid is high.
REQ-012 Port score, output, SCORE_W: accumulated score.
REQ-013 Port combo, output, COUNT_W: current consecutive non-MISS count.
REQ-014 Port max_combo, output, COUNT_W: highest combo reached this song.
REQ-015 Port notes_judged, output, COUNT_W: judgments accepted this song.
REQ-016 Port perfect_cnt, output, COUNT_W: number of PERFECT judgments accepted.
REQ-017 Port miss_cnt, output, COUNT_W: number of MISS judgments accepted.
REQ-018 Port playing, output, 1: high in the PLAY state.
REQ-019 Port done, output, 1: high in the DONE state.
REQ-020 Port full_combo, output, 1: high in DONE when miss_cnt is 0.

Function
REQ-021 The FSM SHALL have three states: IDLE, PLAY and DONE.
REQ-022 Transition IDLE->PLAY: on start; on that same edge all counters and score SHALL be zeroed.
REQ-023 Transition PLAY->DONE: on the edge that accepts the judgment making notes_judged equal TOTAL_NOTES.
REQ-024 Transition DONE->IDLE: on clear only; start in DONE SHALL be ignored.
REQ-025 clear SHALL take priority over start and judge_valid in every state, return the FSM to IDLE and zero every output.
REQ-026 judge_valid SHALL be accepted only in PLAY; in IDLE or DONE it SHALL be ignored with no output change.
REQ-027 start and judge_valid asserted together in IDLE: the FSM SHALL enter PLAY and the judgment SHALL be dropped.
REQ-028 Define STEP = MAX_SCORE/TOTAL_NOTES (integer). Increments: PERFECT = STEP, GREAT = (STEP*3)/4, GOOD = STEP/2, MISS = 0; all computed at elaboration.
REQ-029 Addition SHALL use SCORE_W+1 bits, and the result SHALL saturate at MAX_SCORE.
REQ-030 On the final accepted judgment, if perfect_cnt (after update) equals TOTAL_NOTES, score SHALL be forced to exactly MAX_SCORE, correcting integer-division remainder.
REQ-031 On a non-MISS judgment, combo SHALL increment, saturating at 2^COUNT_W-1; on a MISS judgment, combo SHALL become 0.
REQ-032 max_combo SHALL be updated on the same edge as combo to max(max_combo, new combo), so it never lags combo.
REQ-033 notes_judged, perfect_cnt and miss_cnt SHALL increment on the accepting edge.
REQ-034 All outputs SHALL be registered; a judgment sampled on edge N SHALL be visible after edge N, giving a latency of 1 cycle.
REQ-035 Back-to-back judge_valid on consecutive cycles SHALL each be accepted; no throughput limit.

Reset
REQ-036 Asserting rst SHALL immediately force IDLE, set score, combo, max_combo, notes_judged, perfect_cnt and miss_cnt to 0, and set playing, done and full_combo to 0, including mid-song.
REQ-037 After rst deasserts, the block SHALL remain in IDLE until start.

Verification (defaults; STEP=31250, GREAT=23437, GOOD=15625)
REQ-038 start, then 32 consecutive PERFECT judgments -> score=1000000, combo=32, max_combo=32, done=1, full_combo=1.
REQ-039 start, then 10 PERFECT, 1 MISS, 5 GREAT -> score=429685, combo=5, max_combo=10, miss_cnt=1, playing=1.
REQ-040 start, then 32 GOOD -> score=500000, done=1, full_combo=1; a 33rd judge_valid -> no change.
REQ-041 judge_valid with start in IDLE, then a PERFECT in PLAY -> score=31250, notes_judged=1.
REQ-042 rst asserted mid-song after 7 judgments -> all outputs 0 asynchronously; IDLE; next judge_valid ignored until start.
REQ-043 TOTAL_NOTES=3, MAX_SCORE=1000000, three PERFECT -> score=1000000 (not 999999), done=1.
